cache_mem_responder: RTL and testbench

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

---
 rtl/cache_mem_responder.sv | 147 ++++++++++++++
 tb/tb_cache_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Line-granular memory responder for a cache: fixed-latency 16-byte fill and writeback bursts.
// Optional macro CRIT_WORD_FIRST_EN starts each burst at req_addr[3:0] (wrapping) instead of offset 0.
module cache_mem_responder #(
   parameter int ADDRESS_WORD_SIZE = 32,
   parameter int BLOCK_SIZE        = 16,
   parameter int LATENCY           = 4,
   parameter int MEM_LINES         = 64
) (
   input  logic                         clk,
   input  logic                         rst_b,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic [ADDRESS_WORD_SIZE-1:0] req_addr,
   input  logic [7:0]                   wr_data,
   output logic                         wr_ready,
   output logic [7:0]                   rd_data,
   output logic                         rd_valid,
   output logic                         done,
   output logic                         busy
);

   localparam int         IDX_W     = $clog2(MEM_LINES);
   localparam logic [3:0] LAST_BEAT = 4'(BLOCK_SIZE - 1);
   localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

   typedef enum logic [2:0] {IDLE, WAIT, RD_BURST, WR_BURST, DONE} state_t;

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic [3:0]       r_beat;
   logic             r_write;
   logic [IDX_W-1:0] r_idx;
   logic [3:0]       r_start;
   logic             r_req_ready;
   logic             r_rd_valid;
   logic             r_wr_ready;
   logic             r_done;
   logic             r_busy;
   logic [7:0]       r_rd_data;
   logic [7:0]       r_mem [MEM_LINES*16];

   logic [3:0]       w_start;
   logic [3:0]       w_off;
   logic [3:0]       w_next_off;
   logic             w_unused_addr;

`ifdef CRIT_WORD_FIRST_EN
   assign w_start = req_addr[3:0];
`else
   assign w_start = 4'd0;
`endif

   // Offsets wrap within the line; only the index bits select storage.
   assign w_off         = r_start + r_beat;
   assign w_next_off    = r_start + r_beat + 4'd1;
   assign w_unused_addr = ^req_addr;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_beat      <= 4'd0;
         r_write     <= 1'b0;
         r_idx       <= '0;
         r_start     <= 4'd0;
         r_req_ready <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_wr_ready  <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_rd_data   <= 8'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_state     <= WAIT;
                  r_cnt       <= WAIT_INIT;
                  r_write     <= req_write;
                  r_idx       <= req_addr[IDX_W+3:4];
                  r_start     <= w_start;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
               end else begin
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_beat <= 4'd0;
                  if (r_write) begin
                     r_state    <= WR_BURST;
                     r_wr_ready <= 1'b1;
                  end else begin
                     r_state    <= RD_BURST;
                     r_rd_valid <= 1'b1;
                     r_rd_data  <= r_mem[{r_idx, r_start}];
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RD_BURST: begin
               if (r_beat == LAST_BEAT) begin
                  r_state    <= DONE;
                  r_rd_valid <= 1'b0;
                  r_done     <= 1'b1;
               end else begin
                  r_beat    <= r_beat + 4'd1;
                  r_rd_data <= r_mem[{r_idx, w_next_off}];
               end
            end
            WR_BURST: begin
               if (r_beat == LAST_BEAT) begin
                  r_state    <= DONE;
                  r_wr_ready <= 1'b0;
                  r_done     <= 1'b1;
               end else begin
                  r_beat <= r_beat + 4'd1;
               end
            end
            DONE: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Storage survives reset; a reset edge mid-writeback does not commit that beat.
   always_ff @(posedge clk) begin
      if (rst_b && r_state == WR_BURST)
         r_mem[{r_idx, w_off}] <= wr_data;
   end

   assign req_ready = r_req_ready;
   assign wr_ready  = r_wr_ready;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign done      = r_done;
   assign busy      = r_busy;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: reset, writeback, fill, critical-byte order,
// aliasing, mid-burst reset and ignored requests. Cycle k = cycle following edge E0+k.
module tb_cache_mem_responder;

   logic        clk = 1'b0;
   logic        rst_b, req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic [7:0]  wr_data, rd_data;
   logic        wr_ready, rd_valid, done, busy;
   int          checks = 0;
   int          errors = 0;

`ifdef CRIT_WORD_FIRST_EN
   localparam bit CRIT = 1'b1;
`else
   localparam bit CRIT = 1'b0;
`endif

   always #5 clk = ~clk;

   cache_mem_responder #(
      .ADDRESS_WORD_SIZE(32), .BLOCK_SIZE(16), .LATENCY(4), .MEM_LINES(64)
   ) dut (
      .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .busy(busy)
   );

   // Presents a request for one edge; returns in cycle k=0 with req_valid still high.
   task automatic issue(input bit wr, input logic [31:0] addr);
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = addr;
      @(negedge clk);
   endtask

   task automatic wr_line(input logic [31:0] addr, input logic [7:0] base);
      issue(1'b1, addr);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         wr_data = base + 8'(i);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_b = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; wr_data = '0;
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
      rst_b = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_writeback();
      issue(1'b1, 32'h1000_0000);
      req_valid = 1'b0;
      checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL wb_accept: busy %b ready %b want 1 0", busy, req_ready); end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL wb_wait k=%0d: wr_ready %b want 0", k, wr_ready); end
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL wb_beat %0d: wr_ready %b rd_valid %b done %b want 1 0 0", i, wr_ready, rd_valid, done);
         end
         wr_data = 8'(i);
      end
      @(negedge clk);
      checks++; if (done !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL wb_done: done %b wr_ready %b want 1 0", done, wr_ready); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wb_idle: done %b ready %b busy %b want 0 1 0", done, req_ready, busy); end
   endtask

   task automatic test_fill();
      issue(1'b0, 32'h1000_0000);
      req_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fill_wait k=%0d: rd_valid %b want 0", k, rd_valid); end
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b1 || wr_ready !== 1'b0 || rd_data !== 8'(i)) begin
            errors++; $display("FAIL fill_beat %0d: rd_valid %b wr_ready %b data %h want 1 0 %h", i, rd_valid, wr_ready, rd_data, 8'(i));
         end
      end
      @(negedge clk);
      checks++; if (done !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL fill_done: done %b rd_valid %b want 1 0", done, rd_valid); end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fill_idle: ready %b busy %b want 1 0", req_ready, busy); end
   endtask

   task automatic test_crit_word();
      logic [7:0] exp;
      issue(1'b0, 32'h1000_0005);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         exp = CRIT ? 8'((5 + i) % 16) : 8'(i);
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++; $display("FAIL crit_beat %0d: rd_valid %b data %h want 1 %h", i, rd_valid, rd_data, exp);
         end
      end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL crit_done: got %b want 1", done); end
      @(negedge clk);
   endtask

   task automatic test_alias();
      wr_line(32'h2000_0400, 8'hA0);
      issue(1'b0, 32'h3000_0400);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'hA0 + 8'(i)) begin
            errors++; $display("FAIL alias_beat %0d: rd_valid %b data %h want 1 %h", i, rd_valid, rd_data, 8'hA0 + 8'(i));
         end
      end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL alias_done: got %b want 1", done); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_burst();
      bit seen_done;
      issue(1'b0, 32'h1000_0000);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++; if (rd_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL midrst_beat %0d: data %h want %h", i, rd_data, 8'hA0 + 8'(i)); end
      end
      rst_b = 1'b0;
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_data !== 8'h00) begin
         errors++; $display("FAIL midrst_abort: rd_valid %b busy %b done %b data %h want 0 0 0 00", rd_valid, busy, done, rd_data);
      end
      rst_b = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
      seen_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || rd_valid !== 1'b0) seen_done = 1'b1;
      end
      checks++; if (seen_done) begin errors++; $display("FAIL midrst_quiet: done/rd_valid seen after abort, want none"); end
      issue(1'b0, 32'h3000_0400);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'hA0 + 8'(i)) begin
            errors++; $display("FAIL midrst_refill %0d: rd_valid %b data %h want 1 %h", i, rd_valid, rd_data, 8'hA0 + 8'(i));
         end
      end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_refill_done: got %b want 1", done); end
      @(negedge clk);
   endtask

   task automatic test_ignore_req();
      issue(1'b0, 32'h1000_0000);
      req_addr = 32'h0000_0010; req_write = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b1 || wr_ready !== 1'b0 || rd_data !== 8'hA0 + 8'(i)) begin
            errors++; $display("FAIL ignore_beat %0d: rd_valid %b wr_ready %b data %h want 1 0 %h", i, rd_valid, wr_ready, rd_data, 8'hA0 + 8'(i));
         end
      end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b want 1", done); end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: ready %b busy %b want 1 0", req_ready, busy); end
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL ignore_no_queue: busy %b wr_ready %b want 0 0", busy, wr_ready); end
   endtask

   initial begin
      test_reset();
      test_writeback();
      test_fill();
      test_crit_word();
      test_alias();
      test_reset_mid_burst();
      test_ignore_req();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
